// File: rtl/project_select_pkg.sv
// Shared definitions for the project select controller: register offsets,
// field positions and the switch FSM state encoding.
package project_select_pkg;

  // Register index taken from adr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_GUARD  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // Field positions
  localparam int CTRL_EN_BIT     = 31;
  localparam int STATUS_EN_BIT   = 8;
  localparam int STATUS_BUSY_BIT = 9;

  // Switch FSM: IDLE holds the current grant, GUARD is the all-off window
  typedef enum logic {
    IDLE  = 1'b0,
    GUARD = 1'b1
  } state_e;

endpackage

// File: rtl/project_select_wb_regs.sv
// Wishbone slave for the project select controller: address decode,
// single-cycle ack, registered read data, and the CTRL/GUARD registers.
// A CTRL write produces a same-cycle ctrl_wr_o pulse carrying the decoded
// effective request so the FSM can act on the accept edge itself.
module project_select_wb_regs
  import project_select_pkg::*;
#(
  parameter int          NUM_PROJECTS = 8,
  parameter int          SEL_W        = $clog2(NUM_PROJECTS),
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          GUARD_RESET  = 4,
  parameter int          GUARD_W      = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_dat_i,
  input  logic [31:0]        wbs_adr_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  input  logic [SEL_W-1:0]   cur_idx_i,
  input  logic               cur_en_i,
  input  logic               busy_i,
  output logic [GUARD_W-1:0] guard_o,
  output logic               ctrl_wr_o,
  output logic               req_en_o,
  output logic [SEL_W-1:0]   req_idx_o
);

  logic               ack_q;
  logic [31:0]        dat_q, dat_d;
  logic [SEL_W-1:0]   ctrl_idx_q, ctrl_idx_d;
  logic               ctrl_en_q, ctrl_en_d;
  logic [GUARD_W-1:0] guard_q, guard_d;
  logic [31:0]        rdata;
  logic               hit, accept;
  logic [1:0]         reg_sel;
  logic               unused_ok;

  assign hit     = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  // Only one access per two cycles: a request is not re-accepted while acked
  assign accept  = wbs_stb_i & wbs_cyc_i & ~ack_q & hit;
  assign reg_sel = wbs_adr_i[3:2];

  // Byte-granular register writes; bits outside a register's fields are dropped
  always_comb begin
    ctrl_idx_d = ctrl_idx_q;
    ctrl_en_d  = ctrl_en_q;
    guard_d    = guard_q;
    if (accept && wbs_we_i && reg_sel == REG_CTRL) begin
      if (wbs_sel_i[0]) ctrl_idx_d = wbs_dat_i[SEL_W-1:0];
      if (wbs_sel_i[3]) ctrl_en_d  = wbs_dat_i[CTRL_EN_BIT];
    end
    if (accept && wbs_we_i && reg_sel == REG_GUARD) begin
      for (int i = 0; i < GUARD_W; i++) begin
        if (wbs_sel_i[i/8]) guard_d[i] = wbs_dat_i[i];
      end
    end
  end

  // Effective request uses the freshly merged CTRL value; out-of-range or
  // disabled targets collapse to "none" with a zero index
  assign ctrl_wr_o = accept & wbs_we_i & (reg_sel == REG_CTRL);
  assign req_en_o  = ctrl_en_d &&
                     ({{(32-SEL_W){1'b0}}, ctrl_idx_d} < NUM_PROJECTS);
  assign req_idx_o = req_en_o ? ctrl_idx_d : '0;

  // Read mux; unused bits and the reserved slot read as zero
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL: begin
        rdata[SEL_W-1:0]   = ctrl_idx_q;
        rdata[CTRL_EN_BIT] = ctrl_en_q;
      end
      REG_STATUS: begin
        rdata[SEL_W-1:0]       = cur_idx_i;
        rdata[STATUS_EN_BIT]   = cur_en_i;
        rdata[STATUS_BUSY_BIT] = busy_i;
      end
      REG_GUARD: rdata[GUARD_W-1:0] = guard_q;
      default:   rdata = '0;
    endcase
  end

  // Read data is only non-zero during the ack cycle of a read
  assign dat_d = (accept && !wbs_we_i) ? rdata : '0;

  // Bus response and register state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      ctrl_idx_q <= '0;
      ctrl_en_q  <= 1'b0;
      guard_q    <= GUARD_W'(GUARD_RESET);
    end else begin
      ack_q      <= accept;
      dat_q      <= dat_d;
      ctrl_idx_q <= ctrl_idx_d;
      ctrl_en_q  <= ctrl_en_d;
      guard_q    <= guard_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign guard_o   = guard_q;
  assign unused_ok = ^{wbs_adr_i[1:0], wbs_dat_i};

endmodule

// File: rtl/project_select_ctrl.sv
// Project select controller: grants the shared user resources to at most one
// wrapped project. Switches are break-before-make with a programmable all-off
// guard window; the last request written during the window wins.
module project_select_ctrl
  import project_select_pkg::*;
#(
  parameter int          NUM_PROJECTS = 8,
  parameter int          SEL_W        = $clog2(NUM_PROJECTS),
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          GUARD_RESET  = 4,
  parameter int          GUARD_W      = 8
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_dat_i,
  input  logic [31:0]             wbs_adr_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [NUM_PROJECTS-1:0] active_o,
  output logic                    switching_o
);

  state_e                  state_q, state_d;
  logic [GUARD_W-1:0]      cnt_q, cnt_d;
  logic                    pend_en_q, pend_en_d;
  logic [SEL_W-1:0]        pend_idx_q, pend_idx_d;
  logic                    cur_en_q, cur_en_d;
  logic [SEL_W-1:0]        cur_idx_q, cur_idx_d;
  logic [NUM_PROJECTS-1:0] active_q, active_d;

  logic [GUARD_W-1:0]      guard;
  logic [GUARD_W-1:0]      guard_eff;
  logic                    ctrl_wr, req_en;
  logic [SEL_W-1:0]        req_idx;

  project_select_wb_regs #(
    .NUM_PROJECTS (NUM_PROJECTS),
    .SEL_W        (SEL_W),
    .BASE_ADDR    (BASE_ADDR),
    .GUARD_RESET  (GUARD_RESET),
    .GUARD_W      (GUARD_W)
  ) u_regs (
    .clk_i     (wb_clk_i),
    .rst_n_i   (wb_rst_n_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .cur_idx_i (cur_idx_q),
    .cur_en_i  (cur_en_q),
    .busy_i    (state_q == GUARD),
    .guard_o   (guard),
    .ctrl_wr_o (ctrl_wr),
    .req_en_o  (req_en),
    .req_idx_o (req_idx)
  );

  // A zero guard still gives one all-off cycle so grants never overlap
  assign guard_eff = (guard == '0) ? GUARD_W'(1) : guard;

  // Next-state logic for the switch FSM, guard counter and grant vector
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_en_d  = pend_en_q;
    pend_idx_d = pend_idx_q;
    cur_en_d   = cur_en_q;
    cur_idx_d  = cur_idx_q;
    active_d   = active_q;
    case (state_q)
      IDLE: begin
        // Rewriting the current grant is a no-op, so active_o never glitches
        if (ctrl_wr && (req_en != cur_en_q || req_idx != cur_idx_q)) begin
          active_d   = '0;
          cnt_d      = guard_eff;
          pend_en_d  = req_en;
          pend_idx_d = req_idx;
          state_d    = GUARD;
        end
      end
      GUARD: begin
        // Later requests replace the pending one without extending the window
        if (ctrl_wr) begin
          pend_en_d  = req_en;
          pend_idx_d = req_idx;
        end
        if (cnt_q == GUARD_W'(1)) begin
          active_d = '0;
          if (pend_en_d) active_d[pend_idx_d] = 1'b1;
          cur_en_d  = pend_en_d;
          cur_idx_d = pend_idx_d;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - GUARD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and grant registers; reset releases every project at once
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_en_q  <= 1'b0;
      pend_idx_q <= '0;
      cur_en_q   <= 1'b0;
      cur_idx_q  <= '0;
      active_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_en_q  <= pend_en_d;
      pend_idx_q <= pend_idx_d;
      cur_en_q   <= cur_en_d;
      cur_idx_q  <= cur_idx_d;
      active_q   <= active_d;
    end
  end

  assign active_o    = active_q;
  assign switching_o = (state_q == GUARD);

endmodule

// File: tb/tb_project_select_ctrl.sv
// Self-checking bench for project_select_ctrl: Wishbone register access,
// break-before-make switching, retargeting inside the guard window and reset.
module tb_project_select_ctrl;

  localparam logic [31:0] BASE     = 32'h3000_0000;
  localparam logic [31:0] A_CTRL   = BASE + 32'h0;
  localparam logic [31:0] A_STATUS = BASE + 32'h4;
  localparam logic [31:0] A_GUARD  = BASE + 32'h8;
  localparam logic [31:0] A_RSVD   = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_i, adr;
  logic        ack;
  logic [31:0] dat_o;
  logic [7:0]  active;
  logic        switching;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_act_q[$];
  logic        exp_sw_q[$];
  logic [31:0] exp_rd_q[$];

  project_select_ctrl dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_dat_i   (dat_i),
    .wbs_adr_i   (adr),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (dat_o),
    .active_o    (active),
    .switching_o (switching)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All tasks enter and leave 1 time unit after a rising edge.
  task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input string name);
    bit got = 0;
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = a; dat_i = d; sel = s;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) got = 1;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: ack=%b, required 1 within 8 cycles", name, ack);
    end
    $display("WR  %-14s adr=%h dat=%h sel=%h", name, a, d, s);
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] expv,
                         input logic [31:0] mask, input string name);
    bit got = 0;
    logic [31:0] e;
    logic [31:0] obs = '0;
    exp_rd_q.push_back(expv);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin got = 1; obs = dat_o; end
    end
    stb = 1'b0; cyc = 1'b0;
    e = exp_rd_q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: no ack, required read data %h", name, e);
    end else if ((obs & mask) !== (e & mask)) begin
      errors++;
      $display("FAIL %s: dat_o=%h, required %h (mask %h)", name, obs, e, mask);
    end
    $display("RD  %-14s adr=%h dat=%h exp=%h", name, a, obs, e);
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0 || dat_o !== 32'h0) begin
      errors++;
      $display("FAIL %s_ack_width: ack=%b dat_o=%h, required 0/0", name, ack, dat_o);
    end
  endtask

  // Expected grant trace after a switch: g all-off cycles, then val
  task automatic push_switch(input int g, input logic [7:0] val, input int n);
    for (int c = 1; c <= n; c++) begin
      exp_act_q.push_back(c <= g ? 8'h00 : val);
      exp_sw_q.push_back(c <= g);
    end
  endtask

  task automatic run_active(input int n, input string name);
    logic [7:0] ea;
    logic       es;
    for (int c = 0; c < n; c++) begin
      ea = exp_act_q.pop_front();
      es = exp_sw_q.pop_front();
      checks++;
      if (active !== ea || switching !== es) begin
        errors++;
        $display("FAIL %s: active=%h switching=%b, required %h/%b",
                 name, active, switching, ea, es);
      end
      checks++;
      if (!$onehot0(active)) begin
        errors++;
        $display("FAIL %s_onehot0: active=%h is not onehot0", name, active);
      end
      @(posedge clk); #1;
    end
    $display("CHK %-14s %0d cycles traced", name, n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stb = 0; cyc = 0; we = 0; sel = 0; dat_i = 0; adr = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (active !== 8'h00 || switching !== 1'b0 || ack !== 1'b0 || dat_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: active=%h sw=%b ack=%b dat=%h, required 0", active,
               switching, ack, dat_o);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    wb_read(A_STATUS, 32'h0, 32'hFFFF_FFFF, "reset_status");
    wb_read(A_GUARD, 32'h4, 32'hFFFF_FFFF, "reset_guard");
    wb_read(A_CTRL, 32'h0, 32'hFFFF_FFFF, "reset_ctrl");
  endtask

  task automatic test_switch_guard4();
    push_switch(4, 8'h04, 8);
    wb_write(A_CTRL, 32'h8000_0002, 4'hF, "ctrl_to_2");
    run_active(8, "switch_g4");
    wb_read(A_STATUS, 32'h102, 32'hFFFF_FFFF, "status_2");
  endtask

  task automatic test_guard_zero();
    wb_write(A_GUARD, 32'h0, 4'hF, "guard_0");
    wb_read(A_GUARD, 32'h0, 32'hFFFF_FFFF, "guard_rd_0");
    push_switch(1, 8'h20, 4);
    wb_write(A_CTRL, 32'h8000_0005, 4'hF, "ctrl_to_5");
    run_active(4, "switch_g0");
    wb_read(A_STATUS, 32'h105, 32'hFFFF_FFFF, "status_5");
  endtask

  task automatic test_none();
    wb_write(A_GUARD, 32'h4, 4'hF, "guard_4");
    push_switch(4, 8'h00, 7);
    wb_write(A_CTRL, 32'h0000_0005, 4'hF, "ctrl_disable");
    run_active(7, "switch_none");
    wb_read(A_STATUS, 32'h0, 32'h0000_0300, "status_none");
  endtask

  task automatic test_retarget();
    // Cycle 1 traced, cycle 2 spent driving the second write (accepted at E0+2)
    exp_act_q.push_back(8'h00); exp_sw_q.push_back(1'b1);
    for (int c = 3; c <= 8; c++) begin
      exp_act_q.push_back(c <= 4 ? 8'h00 : 8'h80);
      exp_sw_q.push_back(c <= 4);
    end
    wb_write(A_CTRL, 32'h8000_0005, 4'hF, "ctrl_to_5");
    run_active(1, "retarget_c1");
    wb_write(A_CTRL, 32'h8000_0007, 4'hF, "ctrl_to_7");
    run_active(6, "retarget");
    wb_read(A_STATUS, 32'h107, 32'hFFFF_FFFF, "status_7");
  endtask

  task automatic test_rewrite();
    push_switch(0, 8'h80, 6);
    wb_write(A_CTRL, 32'h8000_0007, 4'hF, "ctrl_same");
    run_active(6, "rewrite");
  endtask

  task automatic test_unmapped();
    bit got = 0;
    wb_write(A_RSVD, 32'hFFFF_FFFF, 4'hF, "rsvd_wr");
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL rsvd_ack_width: ack=%b, required 0", ack);
    end
    wb_read(A_RSVD, 32'h0, 32'hFFFF_FFFF, "rsvd_rd");
    wb_write(A_GUARD, 32'h1234_0009, 4'hE, "guard_hi_bytes");
    wb_read(A_GUARD, 32'h4, 32'hFFFF_FFFF, "guard_keep");
    wb_write(A_GUARD, 32'h1234_0009, 4'h1, "guard_lo_byte");
    wb_read(A_GUARD, 32'h9, 32'hFFFF_FFFF, "guard_9");
    // Address outside the decoded window must never be acked
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h10; dat_i = 32'h8000_0001;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) got = 1;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    checks++;
    if (got) begin
      errors++;
      $display("FAIL nodecode_ack: ack seen=1, required 0");
    end
    $display("WR  %-14s adr=%h acked=%0d", "nodecode", BASE + 32'h10, got);
  endtask

  task automatic test_reset_mid();
    wb_write(A_CTRL, 32'h8000_0001, 4'hF, "ctrl_to_1");
    @(posedge clk); #1;
    checks++;
    if (switching !== 1'b1 || active !== 8'h00) begin
      errors++;
      $display("FAIL mid_switch: switching=%b active=%h, required 1/00", switching, active);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (switching !== 1'b0 || active !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: switching=%b active=%h, required 0/00", switching, active);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wb_read(A_STATUS, 32'h0, 32'hFFFF_FFFF, "status_rst");
    wb_read(A_GUARD, 32'h4, 32'hFFFF_FFFF, "guard_rst");
    push_switch(0, 8'h00, 12);
    run_active(12, "post_reset");
  endtask

  initial begin
    test_reset();
    test_switch_guard4();
    test_guard_zero();
    test_none();
    test_retarget();
    test_rewrite();
    test_unmapped();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
